// File: rtl/led_uart_pkg.sv
// Shared constants, state encodings and message table for the LED status
// reporter and its UART bit serialiser.
package led_uart_pkg;

    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_N  = 8'h4E;
    localparam logic [7:0] ASCII_F  = 8'h46;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [2:0] MSG_LEN_ON  = 3'd4;
    localparam logic [2:0] MSG_LEN_OFF = 3'd5;

    typedef logic [1:0] msg_state_t;
    localparam msg_state_t MSG_IDLE = 2'd0;
    localparam msg_state_t MSG_LOAD = 2'd1;
    localparam msg_state_t MSG_SEND = 2'd2;
    localparam msg_state_t MSG_NEXT = 2'd3;

    typedef logic [1:0] ser_state_t;
    localparam ser_state_t SER_IDLE  = 2'd0;
    localparam ser_state_t SER_START = 2'd1;
    localparam ser_state_t SER_DATA  = 2'd2;
    localparam ser_state_t SER_STOP  = 2'd3;

    // Byte idx of "ON\r\n" (on=1) or "OFF\r\n" (on=0).
    function automatic logic [7:0] msg_byte(input logic on, input logic [2:0] idx);
        logic [7:0] b;
        if (on) begin
            case (idx)
                3'd0:    b = ASCII_O;
                3'd1:    b = ASCII_N;
                3'd2:    b = ASCII_CR;
                default: b = ASCII_LF;
            endcase
        end else begin
            case (idx)
                3'd0:    b = ASCII_O;
                3'd1:    b = ASCII_F;
                3'd2:    b = ASCII_F;
                3'd3:    b = ASCII_CR;
                default: b = ASCII_LF;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART bit serialiser. A start strobe accepted in the last stop-bit
// cycle chains the next byte with no idle gap; done pulses in that cycle.
//
// state | meaning
// IDLE  | line idle high, waiting for start
// START | start bit (0)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (1)
module uart_tx_core
    import led_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    ser_state_t  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        baud_end;

    assign baud_end = (baud_q == BAUD_LAST);
    assign done     = (state_q == SER_STOP) && baud_end;
    assign tx       = tx_q;

    // Next-state, bit timing and serial output.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            SER_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = SER_START;
                    tx_d    = 1'b0;
                    shift_d = data;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            SER_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = SER_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            SER_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = SER_STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (start) begin
                        state_d = SER_START;
                        tx_d    = 1'b0;
                        shift_d = data;
                    end else begin
                        state_d = SER_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
        endcase
    end

    // Serialiser registers; line forced idle-high by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/led_status_reporter.sv
// Sends "ON\r\n" or "OFF\r\n" over UART on request. Optional macro
// LED_REPORT_AUTO_EN makes any led change act as a request as well.
// The first byte ('O') is common to both messages, so the serialiser is
// launched in the trigger cycle while led is latched for the rest.
//
// state | meaning
// IDLE  | no message; trigger launches byte 0 and latches led
// LOAD  | first cycle of a message (pending cleared at launch)
// SEND  | waiting for serialiser done; launches next byte or next message
// NEXT  | advance byte index after a chained byte launch
module led_status_reporter
    import led_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic led,
    input  logic query,
    output logic tx,
    output logic busy
);

    msg_state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       on_q, on_d;
    logic       pending_q, pending_d;
    logic       trig;
    logic       launch;
    logic       last_byte;
    logic       core_start;
    logic [7:0] core_byte;
    logic       core_done;

`ifdef LED_REPORT_AUTO_EN
    logic led_q, led_prev_q;

    // led history: a difference between the last two samples is a trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q      <= 1'b0;
            led_prev_q <= 1'b0;
        end else begin
            led_q      <= led;
            led_prev_q <= led_q;
        end
    end

    assign trig = query | (led_q ^ led_prev_q);
`else
    assign trig = query;
`endif

    assign busy      = (state_q != MSG_IDLE);
    assign last_byte = (idx_q == (on_q ? MSG_LEN_ON - 3'd1 : MSG_LEN_OFF - 3'd1));

    // Message sequencing, byte selection and pending-request coalescing.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        on_d       = on_q;
        pending_d  = pending_q;
        launch     = 1'b0;
        core_start = 1'b0;
        core_byte  = ASCII_O;
        case (state_q)
            MSG_IDLE: begin
                if (trig || pending_q) launch = 1'b1;
            end
            MSG_LOAD: begin
                state_d = MSG_SEND;
            end
            MSG_SEND: begin
                if (core_done) begin
                    if (!last_byte) begin
                        core_start = 1'b1;
                        core_byte  = msg_byte(on_q, idx_q + 3'd1);
                        state_d    = MSG_NEXT;
                    end else if (pending_q || trig) begin
                        launch = 1'b1;
                    end else begin
                        state_d = MSG_IDLE;
                    end
                end
            end
            default: begin
                idx_d   = idx_q + 3'd1;
                state_d = MSG_SEND;
            end
        endcase
        if (launch) begin
            core_start = 1'b1;
            core_byte  = ASCII_O;
            on_d       = led;
            idx_d      = '0;
            state_d    = MSG_LOAD;
            pending_d  = 1'b0;
        end else if (trig && busy) begin
            pending_d = 1'b1;
        end
    end

    // Message FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MSG_IDLE;
            idx_q     <= '0;
            on_q      <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            on_q      <= on_d;
            pending_q <= pending_d;
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .data  (core_byte),
        .tx    (tx),
        .done  (core_done)
    );

endmodule
